// File: rtl/arm_hazard_ctrl.sv
// arm_hazard_ctrl: hazard, stall, flush and forwarding controller for the 5-stage ARM pipeline
// Ports: clk, reset (asynchronous, active-low)
//   RA1D/RA2D/WA3D, RegWriteD, MemtoRegD, PCWrPendD : decode-stage instruction info
//   BranchTakenE : branch in E taken; MemReqM/MemReadyM : data-memory access handshake
//   ForwardAE/ForwardBE : 00 regfile, 10 ALUOutM, 01 ResultW
//   StallF/D/E/M, FlushD/E/W : stage register hold / bubble controls
//   stall_cnt : saturating count of StallF cycles since reset
// Define ARM_HZ_FORWARD_EN to enable forwarding; without it any RAW against E or M stalls.
module arm_hazard_ctrl #(
  parameter int RADDR_W = 4,
  parameter int PC_IDX = 15,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] RA1D,
  input  logic [RADDR_W-1:0] RA2D,
  input  logic [RADDR_W-1:0] WA3D,
  input  logic               RegWriteD,
  input  logic               MemtoRegD,
  input  logic               PCWrPendD,
  input  logic               BranchTakenE,
  input  logic               MemReqM,
  input  logic               MemReadyM,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               StallF,
  output logic               StallD,
  output logic               StallE,
  output logic               StallM,
  output logic               FlushD,
  output logic               FlushE,
  output logic               FlushW,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam logic [RADDR_W-1:0] PC = RADDR_W'(PC_IDX);
  logic ev, eld, epcw, mv, mpcw;
  logic [RADDR_W-1:0] erd, mrd;
  logic memwait, e_hit, raw, pcpend, norm, br, mw;
  assign memwait = MemReqM & ~MemReadyM;
  assign e_hit = ev & (erd != PC) & (erd == RA1D | erd == RA2D);
  assign pcpend = PCWrPendD | epcw | mpcw;
`ifdef ARM_HZ_FORWARD_EN
  logic wv;
  logic [RADDR_W-1:0] wrd, ers1, ers2;
  assign raw = e_hit & eld;
  assign ForwardAE = (ers1 == PC) ? 2'b00 : (mv & mrd == ers1) ? 2'b10 : (wv & wrd == ers1) ? 2'b01 : 2'b00;
  assign ForwardBE = (ers2 == PC) ? 2'b00 : (mv & mrd == ers2) ? 2'b10 : (wv & wrd == ers2) ? 2'b01 : 2'b00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wv <= 1'b0;
      wrd <= '0;
      ers1 <= '0;
      ers2 <= '0;
    end else begin
      wv <= mv & ~StallM;
      wrd <= mrd;
      if (!StallE) begin
        ers1 <= FlushE ? '0 : RA1D;
        ers2 <= FlushE ? '0 : RA2D;
      end
    end
  end
`else
  logic m_hit;
  // regfile writes land in the first half-cycle, so a W producer never needs a stall
  assign m_hit = mv & (mrd != PC) & (mrd == RA1D | mrd == RA2D);
  assign raw = (e_hit & eld) | e_hit | m_hit;
  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;
`endif
  // reset gates the purely input-driven sources so every output reads 0 while held in reset
  assign mw = reset & memwait;
  assign br = reset & ~memwait & BranchTakenE;
  assign norm = reset & ~memwait & ~BranchTakenE;
  assign StallF = mw | (norm & (raw | pcpend));
  assign StallD = mw | (norm & raw);
  assign StallE = mw;
  assign StallM = mw;
  assign FlushD = br | (norm & pcpend);
  assign FlushE = br | (norm & raw);
  assign FlushW = mw;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {ev, eld, epcw, mv, mpcw} <= '0;
      erd <= '0;
      mrd <= '0;
      stall_cnt <= '0;
    end else begin
      if (!StallE) begin
        ev <= ~FlushE & RegWriteD;
        eld <= ~FlushE & MemtoRegD;
        epcw <= ~FlushE & PCWrPendD;
        erd <= FlushE ? '0 : WA3D;
      end
      if (!StallM) begin
        mv <= ev;
        mpcw <= epcw;
        mrd <= erd;
      end
      if (StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
